// File: rtl/tb4004_pkg.sv
// Shared 4004 encodings: sub-cycle numbers, branch-related OPR values,
// the branch sequencer state type and the JCN condition evaluator.
package tb4004_pkg;

    localparam logic [2:0] CYC_A1 = 3'd0;
    localparam logic [2:0] CYC_A2 = 3'd1;
    localparam logic [2:0] CYC_A3 = 3'd2;
    localparam logic [2:0] CYC_M1 = 3'd3;
    localparam logic [2:0] CYC_M2 = 3'd4;
    localparam logic [2:0] CYC_X1 = 3'd5;
    localparam logic [2:0] CYC_X2 = 3'd6;
    localparam logic [2:0] CYC_X3 = 3'd7;

    localparam logic [3:0] OPR_JCN     = 4'h1;
    localparam logic [3:0] OPR_FIM_SRC = 4'h2;
    localparam logic [3:0] OPR_FIN_JIN = 4'h3;
    localparam logic [3:0] OPR_JUN     = 4'h4;
    localparam logic [3:0] OPR_JMS     = 4'h5;
    localparam logic [3:0] OPR_ISZ     = 4'h7;
    localparam logic [3:0] OPR_BBL     = 4'hC;

    localparam int STACK_DEPTH = 3;

    typedef enum logic [2:0] {
        ST_W1,
        ST_W2_JUN,
        ST_W2_JMS,
        ST_W2_JCN,
        ST_W2_ISZ,
        ST_W2_FIM
    } br_state_e;

    // cond = C1 C2 C3 C4 (bit3..bit0); C1 inverts the combined test.
    function automatic logic jcn_cond(input logic [3:0] cond, input logic acc_zero,
                                      input logic carry_f, input logic test_n);
        return ((cond[2] & acc_zero) | (cond[1] & carry_f) | (cond[0] & ~test_n)) ^ cond[3];
    endfunction

endpackage

// File: rtl/addr_stack.sv
// 3-entry circular return-address stack. With BRANCH_STACK_ERR_EN defined a
// depth counter tracks occupancy and a sticky error flags over/underflow.
module addr_stack
    import tb4004_pkg::*;
(
    input  logic        clk,
    input  logic        rstN,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [11:0] push_data_i,
    output logic [11:0] pop_data_o,
`ifdef BRANCH_STACK_ERR_EN
    output logic [1:0]  sp_o,
    output logic        stk_err_o
`else
    output logic [1:0]  sp_o
`endif
);

    localparam logic [1:0] SP_LAST = 2'(STACK_DEPTH - 1);

    logic [11:0] stack_q [STACK_DEPTH];
    logic [1:0]  sp_q;
    logic [1:0]  sp_inc;
    logic [1:0]  sp_dec;

    assign sp_inc     = (sp_q == SP_LAST) ? 2'd0 : sp_q + 2'd1;
    assign sp_dec     = (sp_q == 2'd0) ? SP_LAST : sp_q - 2'd1;
    assign pop_data_o = stack_q[sp_dec];
    assign sp_o       = sp_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
            sp_q <= '0;
        end else if (push_i) begin
            stack_q[sp_q] <= push_data_i;
            sp_q          <= sp_inc;
        end else if (pop_i) begin
            sp_q <= sp_dec;
        end
    end

`ifdef BRANCH_STACK_ERR_EN
    localparam logic [1:0] DEPTH_FULL = 2'(STACK_DEPTH);

    logic [1:0] depth_q;
    logic       err_q;

    // Depth saturates so that a wrapped stack keeps reporting full/empty.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            depth_q <= '0;
            err_q   <= 1'b0;
        end else if (push_i) begin
            if (depth_q == DEPTH_FULL) begin
                err_q <= 1'b1;
            end else begin
                depth_q <= depth_q + 2'd1;
            end
        end else if (pop_i) begin
            if (depth_q == 2'd0) begin
                err_q <= 1'b1;
            end else begin
                depth_q <= depth_q - 2'd1;
            end
        end
    end

    assign stk_err_o = err_q;
`endif

endmodule

// File: rtl/branch_ctrl.sv
// 4004 control-transfer sequencer: decodes JUN/JMS/JCN/ISZ/JIN/BBL/FIM, tracks
// second words and drives the PC load in X3. BRANCH_STACK_ERR_EN adds stkErr.
module branch_ctrl
    import tb4004_pkg::*;
(
    input  logic        clk,
    input  logic        rstN,
    input  logic [2:0]  cycle,
    input  logic [3:0]  romData,
    input  logic [11:0] pcAddr,
    input  logic        accZero,
    input  logic        carry,
    input  logic        testN,
    input  logic        iszNonZero,
    input  logic [7:0]  pairData,
    output logic        pcLoad,
    output logic [11:0] pcLoadData,
    output logic        word2,
`ifdef BRANCH_STACK_ERR_EN
    output logic [1:0]  sp,
    output logic        stkErr
`else
    output logic [1:0]  sp
`endif
);

    br_state_e   state_q, state_d;
    logic [3:0]  opr_q, opa_q, hi_nib_q;
    logic        cond_q, cond_d;
    logic        load, push, pop;
    logic [11:0] target, pop_data;

    // W1 decode; W2 states never decode so data bytes cannot alias opcodes.
    always_comb begin
        state_d = ST_W1;
        cond_d  = 1'b0;
        if (state_q == ST_W1) begin
            case (opr_q)
                OPR_JUN:     state_d = ST_W2_JUN;
                OPR_JMS:     state_d = ST_W2_JMS;
                OPR_JCN: begin
                    state_d = ST_W2_JCN;
                    cond_d  = jcn_cond(opa_q, accZero, carry, testN);
                end
                OPR_ISZ: begin
                    state_d = ST_W2_ISZ;
                    cond_d  = iszNonZero;
                end
                OPR_FIM_SRC: state_d = opa_q[0] ? ST_W1 : ST_W2_FIM;
                default:     state_d = ST_W1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= ST_W1;
            opr_q    <= '0;
            opa_q    <= '0;
            hi_nib_q <= '0;
            cond_q   <= 1'b0;
        end else begin
            if (cycle == CYC_M1) begin
                opr_q <= romData;
            end
            if (cycle == CYC_M2) begin
                opa_q <= romData;
                if (state_q == ST_W1) begin
                    hi_nib_q <= romData;
                end
            end
            if (cycle == CYC_X3) begin
                state_q <= state_d;
                if (state_q == ST_W1) begin
                    cond_q <= cond_d;
                end
            end
        end
    end

    // Page for JCN/ISZ/JIN comes from the already-incremented PC (4004 quirk).
    always_comb begin
        load   = 1'b0;
        push   = 1'b0;
        pop    = 1'b0;
        target = '0;
        if (cycle == CYC_X3) begin
            case (state_q)
                ST_W2_JUN: begin
                    load   = 1'b1;
                    target = {hi_nib_q, opr_q, opa_q};
                end
                ST_W2_JMS: begin
                    load   = 1'b1;
                    push   = 1'b1;
                    target = {hi_nib_q, opr_q, opa_q};
                end
                ST_W2_JCN, ST_W2_ISZ: begin
                    if (cond_q) begin
                        load   = 1'b1;
                        target = {pcAddr[11:8], opr_q, opa_q};
                    end
                end
                ST_W1: begin
                    if (opr_q == OPR_FIN_JIN && opa_q[0]) begin
                        load   = 1'b1;
                        target = {pcAddr[11:8], pairData};
                    end else if (opr_q == OPR_BBL) begin
                        load   = 1'b1;
                        pop    = 1'b1;
                        target = pop_data;
                    end
                end
                default: begin
                    load = 1'b0;
                end
            endcase
        end
    end

    assign pcLoad     = load;
    assign pcLoadData = target;
    assign word2      = (state_q != ST_W1);

    addr_stack u_stack (
        .clk        (clk),
        .rstN       (rstN),
        .push_i     (push),
        .pop_i      (pop),
        .push_data_i(pcAddr),
        .pop_data_o (pop_data),
`ifdef BRANCH_STACK_ERR_EN
        .sp_o       (sp),
        .stk_err_o  (stkErr)
`else
        .sp_o       (sp)
`endif
    );

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: the bench plays ROM and PC, a scoreboard
// queue holds expected jump targets and a monitor checks every X3.
module tb_branch_ctrl;
    import tb4004_pkg::*;

    logic        clk = 1'b0;
    logic        rstN;
    logic [2:0]  cycle;
    logic [3:0]  romData;
    logic [11:0] pcAddr;
    logic        accZero, carry, testN, iszNonZero;
    logic [7:0]  pairData;
    logic        pcLoad;
    logic [11:0] pcLoadData;
    logic        word2;
    logic [1:0]  sp;
`ifdef BRANCH_STACK_ERR_EN
    logic        stkErr;
`endif

    always #5 clk = ~clk;

    branch_ctrl dut (
        .clk       (clk),
        .rstN      (rstN),
        .cycle     (cycle),
        .romData   (romData),
        .pcAddr    (pcAddr),
        .accZero   (accZero),
        .carry     (carry),
        .testN     (testN),
        .iszNonZero(iszNonZero),
        .pairData  (pairData),
        .pcLoad    (pcLoad),
        .pcLoadData(pcLoadData),
        .word2     (word2),
`ifdef BRANCH_STACK_ERR_EN
        .sp        (sp),
        .stkErr    (stkErr)
`else
        .sp        (sp)
`endif
    );

    logic [7:0]  rom [0:4095];
    logic [11:0] exp_q [$];
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every load must match the next queued target and occur in X3.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (pcLoad === 1'b1) begin
                n_assert++;
                if (cycle != CYC_X3) begin
                    n_fail++;
                    $display("FAIL pcLoad_cycle: load seen in cycle %0d, expected only in 7", cycle);
                end else if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pcLoad_unexpected: got load 0x%0h, expected no load", pcLoadData);
                end else begin
                    e = exp_q.pop_front();
                    if (pcLoadData !== e) begin
                        n_fail++;
                        $display("FAIL pcLoadData: got 0x%0h, expected 0x%0h", pcLoadData, e);
                    end
                end
            end else if (cycle == CYC_X3) begin
                n_assert++;
                if (pcLoadData !== 12'h000) begin
                    n_fail++;
                    $display("FAIL pcLoadData_idle: got 0x%0h, expected 0x0", pcLoadData);
                end
            end
        end
    end

    // One full instruction cycle fetched from rom[pcAddr]; acts as the pc block.
    task automatic icycle(input logic exp_w2);
        logic [11:0] f;
        logic [7:0]  w;
        logic        ld;
        logic [11:0] ldd;
        f   = pcAddr;
        w   = rom[f];
        ld  = 1'b0;
        ldd = '0;
        for (int c = 0; c < 8; c++) begin
            if (c == 2) pcAddr = f + 12'd1;
            cycle   = 3'(c);
            romData = (c == 3) ? w[7:4] : (c == 4) ? w[3:0] : 4'h0;
            @(negedge clk);
            if (c == 5) check("word2", {11'b0, word2}, {11'b0, exp_w2});
            if (c == 7) begin
                ld  = pcLoad;
                ldd = pcLoadData;
            end
            @(posedge clk);
            #1;
        end
        if (ld) pcAddr = ldd;
    endtask

    task automatic drained(input string name);
        check(name, 12'(exp_q.size()), 12'd0);
    endtask

    initial begin
        logic [11:0] f;
        logic [7:0]  w;
        rstN = 1'b0; cycle = CYC_X3; romData = '0; pcAddr = '0;
        accZero = 1'b0; carry = 1'b0; testN = 1'b1; iszNonZero = 1'b0; pairData = '0;
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        rom[12'h010] = 8'h4A; rom[12'h011] = 8'h35;
        rom[12'h020] = 8'h51; rom[12'h021] = 8'h00; rom[12'h100] = 8'hC0;
        rom[12'h0F0] = 8'h14; rom[12'h0F1] = 8'h56;
        rom[12'h1FE] = 8'h14; rom[12'h1FF] = 8'h40;
        rom[12'h300] = 8'h1C; rom[12'h301] = 8'h99;
        rom[12'h400] = 8'h12; rom[12'h401] = 8'h10;
        rom[12'h500] = 8'h11; rom[12'h501] = 8'h22;
        rom[12'h600] = 8'h56; rom[12'h601] = 8'h10;
        rom[12'h610] = 8'h56; rom[12'h611] = 8'h20; rom[12'h612] = 8'hC0;
        rom[12'h620] = 8'h56; rom[12'h621] = 8'h30; rom[12'h622] = 8'hC0;
        rom[12'h630] = 8'h56; rom[12'h631] = 8'h40; rom[12'h632] = 8'hC0;
        rom[12'h640] = 8'hC0;
        rom[12'h700] = 8'h20; rom[12'h701] = 8'h41;
        rom[12'h305] = 8'h31;
        rom[12'h800] = 8'h70; rom[12'h801] = 8'h55;
        rom[12'h900] = 8'h59; rom[12'h901] = 8'hA0;
        rom[12'h9A0] = 8'h5A; rom[12'h9A1] = 8'hBC;
        rom[12'h910] = 8'h41; rom[12'h911] = 8'h23; rom[12'h123] = 8'hC0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_pcLoad", {11'b0, pcLoad}, 12'd0);
        check("rst_pcLoadData", pcLoadData, 12'h000);
        check("rst_word2", {11'b0, word2}, 12'd0);
        check("rst_sp", {10'b0, sp}, 12'd0);
`ifdef BRANCH_STACK_ERR_EN
        check("rst_stkErr", {11'b0, stkErr}, 12'd0);
`endif
        rstN = 1'b1;

        // JUN 0x4A 0x35
        pcAddr = 12'h010;
        exp_q.push_back(12'hA35);
        icycle(1'b0); icycle(1'b1);
        check("jun_pc", pcAddr, 12'hA35);
        icycle(1'b0);
        check("jun_next_pc", pcAddr, 12'hA36);
        drained("jun_drained");

        // JMS then BBL
        pcAddr = 12'h020;
        exp_q.push_back(12'h100);
        icycle(1'b0); icycle(1'b1);
        check("jms_pc", pcAddr, 12'h100);
        check("jms_sp", {10'b0, sp}, 12'd1);
        exp_q.push_back(12'h022);
        icycle(1'b0);
        check("bbl_pc", pcAddr, 12'h022);
        check("bbl_sp", {10'b0, sp}, 12'd0);
        drained("jmsbbl_drained");

        // JCN variants
        pcAddr = 12'h0F0; accZero = 1'b1;
        exp_q.push_back(12'h056);
        icycle(1'b0); icycle(1'b1);
        check("jcn_taken_pc", pcAddr, 12'h056);
        pcAddr = 12'h0F0; accZero = 1'b0;
        icycle(1'b0); icycle(1'b1);
        check("jcn_nottaken_pc", pcAddr, 12'h0F2);
        pcAddr = 12'h1FE; accZero = 1'b1;
        exp_q.push_back(12'h240);
        icycle(1'b0); icycle(1'b1);
        check("jcn_page_pc", pcAddr, 12'h240);
        pcAddr = 12'h300; accZero = 1'b0;
        exp_q.push_back(12'h399);
        icycle(1'b0); icycle(1'b1);
        check("jcn_invert_pc", pcAddr, 12'h399);
        pcAddr = 12'h400; carry = 1'b1;
        exp_q.push_back(12'h410);
        icycle(1'b0); icycle(1'b1);
        check("jcn_carry_pc", pcAddr, 12'h410);
        carry = 1'b0;
        pcAddr = 12'h500; testN = 1'b0;
        exp_q.push_back(12'h522);
        icycle(1'b0); icycle(1'b1);
        check("jcn_test_pc", pcAddr, 12'h522);
        testN = 1'b1;
        drained("jcn_drained");

        // Four nested JMS, four BBL
        pcAddr = 12'h600;
        exp_q.push_back(12'h610); icycle(1'b0); icycle(1'b1);
        check("nest1_sp", {10'b0, sp}, 12'd1);
        exp_q.push_back(12'h620); icycle(1'b0); icycle(1'b1);
        check("nest2_sp", {10'b0, sp}, 12'd2);
        exp_q.push_back(12'h630); icycle(1'b0); icycle(1'b1);
        check("nest3_sp", {10'b0, sp}, 12'd0);
`ifdef BRANCH_STACK_ERR_EN
        check("nest3_stkErr", {11'b0, stkErr}, 12'd0);
`endif
        exp_q.push_back(12'h640); icycle(1'b0); icycle(1'b1);
        check("nest4_sp", {10'b0, sp}, 12'd1);
`ifdef BRANCH_STACK_ERR_EN
        check("nest4_stkErr", {11'b0, stkErr}, 12'd1);
`endif
        exp_q.push_back(12'h632); icycle(1'b0);
        check("ret1_sp", {10'b0, sp}, 12'd0);
        exp_q.push_back(12'h622); icycle(1'b0);
        check("ret2_sp", {10'b0, sp}, 12'd2);
        exp_q.push_back(12'h612); icycle(1'b0);
        check("ret3_sp", {10'b0, sp}, 12'd1);
        exp_q.push_back(12'h632); icycle(1'b0);
        check("ret4_sp", {10'b0, sp}, 12'd0);
        check("ret4_pc", pcAddr, 12'h632);
`ifdef BRANCH_STACK_ERR_EN
        check("ret4_stkErr", {11'b0, stkErr}, 12'd1);
`endif
        drained("nest_drained");

        // FIM data byte 0x41 must not act as JMS
        pcAddr = 12'h700;
        icycle(1'b0); icycle(1'b1);
        check("fim_pc", pcAddr, 12'h702);
        icycle(1'b0);
        check("fim_sp", {10'b0, sp}, 12'd0);

        // JIN and ISZ
        pcAddr = 12'h305; pairData = 8'h7C;
        exp_q.push_back(12'h37C);
        icycle(1'b0);
        check("jin_pc", pcAddr, 12'h37C);
        pcAddr = 12'h800; iszNonZero = 1'b1;
        exp_q.push_back(12'h855);
        icycle(1'b0); icycle(1'b1);
        check("isz_taken_pc", pcAddr, 12'h855);
        pcAddr = 12'h800; iszNonZero = 1'b0;
        icycle(1'b0); icycle(1'b1);
        check("isz_fall_pc", pcAddr, 12'h802);
        drained("misc_drained");

        // Reset during the second word of a JMS
        pcAddr = 12'h900;
        exp_q.push_back(12'h9A0);
        icycle(1'b0); icycle(1'b1);
        check("pre_rst_sp", {10'b0, sp}, 12'd1);
        icycle(1'b0);
        f = pcAddr;
        w = rom[f];
        for (int c = 0; c < 6; c++) begin
            if (c == 2) pcAddr = f + 12'd1;
            cycle   = 3'(c);
            romData = (c == 3) ? w[7:4] : (c == 4) ? w[3:0] : 4'h0;
            if (c == 5) begin
                #1 rstN = 1'b0;
                #1;
                check("midrst_pcLoad", {11'b0, pcLoad}, 12'd0);
                check("midrst_sp", {10'b0, sp}, 12'd0);
                check("midrst_word2", {11'b0, word2}, 12'd0);
`ifdef BRANCH_STACK_ERR_EN
                check("midrst_stkErr", {11'b0, stkErr}, 12'd0);
`endif
            end else begin
                @(posedge clk);
                #1;
            end
        end
        cycle = CYC_X3;
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        pcAddr = 12'h910;
        exp_q.push_back(12'h123);
        icycle(1'b0); icycle(1'b1);
        check("postrst_pc", pcAddr, 12'h123);
        exp_q.push_back(12'h000);
        icycle(1'b0);
        check("postrst_bbl_sp", {10'b0, sp}, 12'd2);
        drained("final_drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
